// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
// State encoding, register word offsets and CTRL field positions.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IM = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Modes 10 and 11 fall back to one-shot behaviour.
    function automatic logic is_auto(input logic [3:0] ctrl);
        return ctrl[2:1] == MODE_AUTO;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Down-counting timer with CTRL/PRESET/COUNT registers.
// Raises a level (one-shot) or single-cycle (auto-reload) IRQ on expiry.
module timer_counter
    import timer_pkg::*;
#(
    parameter int               CNT_W        = 32,
    parameter logic [CNT_W-1:0] RESET_PRESET = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_pending;
    state_t           state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl        <= '0;
            preset      <= RESET_PRESET;
            count       <= '0;
            irq_pending <= 1'b0;
            state       <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl[CTRL_EN])
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (count == '0) begin
                        state       <= ST_INT;
                        irq_pending <= 1'b1;
                    end else begin
                        count <= count - ONE;
                    end
                end
                ST_INT: begin
                    if (is_auto(ctrl)) begin
                        irq_pending <= 1'b0;
                        state       <= ST_LOAD;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Bus writes come last so they override the FSM this cycle.
            if (WE) begin
                case (Addr)
                    TC_CTRL: begin
                        ctrl        <= Din[3:0];
                        irq_pending <= 1'b0;
                        state       <= ST_IDLE;
                    end
                    TC_PRESET: begin
                        preset      <= Din[CNT_W-1:0];
                        irq_pending <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr)
            TC_CTRL:   Dout[3:0]       = ctrl;
            TC_PRESET: Dout[CNT_W-1:0] = preset;
            TC_COUNT:  Dout[CNT_W-1:0] = count;
            default:   Dout            = '0;
        endcase
    end

    assign IRQ = irq_pending & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: event-schedule reference model plus
// directed scenarios with literal expectations, then random traffic.
module tb_timer_counter;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    // Reference model: register contents plus edge numbers at which
    // the next load, expiry and post-expiry action are due (-1 = none).
    longint      e;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_pend;
    longint      load_at, fire_at, int_at;

    task automatic model_reset();
        m_ctrl   = '0;
        m_preset = '0;
        m_count  = '0;
        m_pend   = 1'b0;
        load_at  = -1;
        fire_at  = -1;
        int_at   = -1;
    endtask

    task automatic model_step();
        logic [3:0]  c;
        logic [31:0] p;
        e++;
        c = m_ctrl;
        p = m_preset;
        if (load_at == e) begin
            m_count = p;
            fire_at = e + longint'(p) + 1;
            load_at = -1;
        end else if (fire_at == e) begin
            m_pend  = 1'b1;
            int_at  = e + 1;
            fire_at = -1;
        end else if (fire_at > e) begin
            m_count = m_count - 32'd1;
        end
        if (int_at == e) begin
            if (c[2:1] == 2'b01) begin
                m_pend  = 1'b0;
                load_at = e + 1;
            end else begin
                m_ctrl[0] = 1'b0;
            end
            int_at = -1;
        end
        if (WE && Addr == 2'd0) begin
            m_ctrl  = Din[3:0];
            m_pend  = 1'b0;
            load_at = Din[0] ? e + 2 : -1;
            fire_at = -1;
            int_at  = -1;
        end else if (WE && Addr == 2'd1) begin
            m_preset = Din;
            m_pend   = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        checks++;
        if (Dout !== exp_dout(Addr)) begin
            errors++;
            $display("FAIL dout addr=%0d: got %h, want %h", Addr, Dout, exp_dout(Addr));
        end
        checks++;
        if (IRQ !== (m_pend & m_ctrl[3])) begin
            errors++;
            $display("FAIL irq: got %b, want %b", IRQ, m_pend & m_ctrl[3]);
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        WE   = 1'b1;
        Din  = d;
        tick();
        WE = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        e     = 0;
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;

        // 1: reset mid-count at COUNT=7
        wr(TC_PRESET, 32'd10);
        wr(TC_CTRL, 32'h1);
        Addr = TC_COUNT;
        repeat (5) tick();
        @(negedge clk);
        lit("pre_reset_count", Dout, 32'd7);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        lit("reset_count", Dout, 32'd0);
        lit("reset_irq", {31'd0, IRQ}, 32'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        lit("post_reset_count", Dout, 32'd0);
        Addr = TC_PRESET;
        #1;
        lit("post_reset_preset", Dout, 32'd0);

        // 2: one-shot with IM, PRESET=5
        wr(TC_PRESET, 32'd5);
        wr(TC_CTRL, 32'h9);
        Addr = TC_CTRL;
        repeat (7) tick();
        @(negedge clk);
        lit("os_irq_e7", {31'd0, IRQ}, 32'd0);
        tick();
        @(negedge clk);
        lit("os_irq_e8", {31'd0, IRQ}, 32'd1);
        tick();
        @(negedge clk);
        lit("os_irq_held", {31'd0, IRQ}, 32'd1);
        lit("os_ctrl", Dout, 32'h8);
        repeat (4) tick();
        @(negedge clk);
        lit("os_irq_level", {31'd0, IRQ}, 32'd1);
        wr(TC_CTRL, 32'h0);
        @(negedge clk);
        lit("os_irq_clr", {31'd0, IRQ}, 32'd0);

        // 3: auto-reload, PRESET=3 -> pulse every 6 cycles
        wr(TC_PRESET, 32'd3);
        wr(TC_CTRL, 32'hB);
        Addr = TC_COUNT;
        for (int k = 1; k <= 24; k++) begin
            tick();
            @(negedge clk);
            lit("auto_irq", {31'd0, IRQ}, (k % 6 == 0) ? 32'd1 : 32'd0);
        end
        wr(TC_CTRL, 32'h0);

        // 4: PRESET=0 masked, then unmasked
        wr(TC_PRESET, 32'd0);
        wr(TC_CTRL, 32'h1);
        repeat (4) tick();
        @(negedge clk);
        lit("masked_irq", {31'd0, IRQ}, 32'd0);
        wr(TC_PRESET, 32'd0);
        wr(TC_CTRL, 32'h9);
        repeat (2) tick();
        @(negedge clk);
        lit("p0_irq_e2", {31'd0, IRQ}, 32'd0);
        tick();
        @(negedge clk);
        lit("p0_irq_e3", {31'd0, IRQ}, 32'd1);
        wr(TC_CTRL, 32'h0);

        // 5: stop at COUNT=4, COUNT and Addr 3 not writable
        wr(TC_PRESET, 32'd10);
        wr(TC_CTRL, 32'h9);
        repeat (7) tick();
        wr(TC_CTRL, 32'h0);
        Addr = TC_COUNT;
        repeat (5) tick();
        @(negedge clk);
        lit("frozen_count", Dout, 32'd4);
        lit("frozen_irq", {31'd0, IRQ}, 32'd0);
        wr(TC_COUNT, 32'h55);
        wr(2'd3, 32'hFFFF_FFFF);
        Addr = TC_COUNT;
        @(negedge clk);
        lit("count_ro", Dout, 32'd4);
        Addr = 2'd3;
        #1;
        lit("addr3_zero", Dout, 32'd0);

        // 6: CTRL write on the one-shot En-clear edge
        wr(TC_PRESET, 32'd0);
        wr(TC_CTRL, 32'h9);
        repeat (3) tick();
        wr(TC_CTRL, 32'hD);
        Addr = TC_CTRL;
        @(negedge clk);
        lit("race_ctrl", Dout, 32'hD);
        lit("race_irq", {31'd0, IRQ}, 32'd0);
        wr(TC_CTRL, 32'h0);

        // Random traffic checked against the model every cycle
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 70) begin
                wr(TC_CTRL, $urandom);
            end else if (r < 120) begin
                wr(TC_PRESET, $urandom_range(0, 9));
            end else if (r < 140) begin
                wr(($urandom_range(0, 1) == 0) ? TC_COUNT : 2'd3, $urandom);
            end else if (r < 143) begin
                do_reset();
            end else begin
                Addr = 2'($urandom_range(0, 3));
                Din  = $urandom;
                tick();
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
